// File: rtl/display_pkg.sv
// Shared constants for the 4-digit multiplexed seven-segment controller.
// Glyphs are packed {a,b,c,d,e,f,g}: bit 6 = a (top), bit 0 = g (middle).
// Also holds the digit count and the per-slot scan state encoding.
package display_pkg;

  localparam int NUM_DIGITOS = 4;
  localparam int IDX_W       = $clog2(NUM_DIGITOS);

  // Hex glyphs, active-high segments, order a..g.
  localparam logic [6:0] GLIFO_0 = 7'b1111110;
  localparam logic [6:0] GLIFO_1 = 7'b0110000;
  localparam logic [6:0] GLIFO_2 = 7'b1101101;
  localparam logic [6:0] GLIFO_3 = 7'b1111001;
  localparam logic [6:0] GLIFO_4 = 7'b0110011;
  localparam logic [6:0] GLIFO_5 = 7'b1011011;
  localparam logic [6:0] GLIFO_6 = 7'b1011111;
  localparam logic [6:0] GLIFO_7 = 7'b1110000;
  localparam logic [6:0] GLIFO_8 = 7'b1111111;
  localparam logic [6:0] GLIFO_9 = 7'b1111011;
  localparam logic [6:0] GLIFO_A = 7'b1110111;
  localparam logic [6:0] GLIFO_B = 7'b0011111;  // lower-case b
  localparam logic [6:0] GLIFO_C = 7'b1001110;
  localparam logic [6:0] GLIFO_D = 7'b0111101;  // lower-case d
  localparam logic [6:0] GLIFO_E = 7'b1001111;
  localparam logic [6:0] GLIFO_F = 7'b1000111;

  // OFF: scanning disabled (or just out of reset); GUARD: all digits dark at
  // slot start to avoid ghosting; ON: the selected digit is driven.
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_GUARD = 2'd1,
    ST_ON    = 2'd2
  } estado_t;

endpackage

// File: rtl/decodificador_7seg.sv
// Purely combinational hex nibble to seven-segment glyph decoder.
// Ports: valor_i[3:0] hex value in; seg_o[6:0] segments out, {a,b,c,d,e,f,g}.
// No state, no clock; zero latency.
module decodificador_7seg
  import display_pkg::*;
(
  input  logic [3:0] valor_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b0000000;
    unique case (valor_i)
      4'h0: seg_o = GLIFO_0;
      4'h1: seg_o = GLIFO_1;
      4'h2: seg_o = GLIFO_2;
      4'h3: seg_o = GLIFO_3;
      4'h4: seg_o = GLIFO_4;
      4'h5: seg_o = GLIFO_5;
      4'h6: seg_o = GLIFO_6;
      4'h7: seg_o = GLIFO_7;
      4'h8: seg_o = GLIFO_8;
      4'h9: seg_o = GLIFO_9;
      4'hA: seg_o = GLIFO_A;
      4'hB: seg_o = GLIFO_B;
      4'hC: seg_o = GLIFO_C;
      4'hD: seg_o = GLIFO_D;
      4'hE: seg_o = GLIFO_E;
      4'hF: seg_o = GLIFO_F;
      default: seg_o = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/controlador_display.sv
// Four-digit multiplexed seven-segment scan controller with a one-deep load
// shadow that only commits to the display register at frame boundaries.
// Ports: clk, rst_n (async, active-low); en scan enable; cargar/dato load
//   strobe and 16-bit value (dato[3:0] = rightmost digit); blank_ceros
//   leading-zero suppression; ocupado = shadow holds an undisplayed load;
//   an[3:0] active-low digit enables; a..g active-high segments.
// Outputs decode registered state only; a load made while ocupado=1 is dropped.
module controlador_display
  import display_pkg::*;
#(
  parameter int PRESCALER = 50000,  // clock cycles per digit slot, >= GUARD+1
  parameter int GUARD     = 2       // dark cycles at the start of every slot
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cargar,
  input  logic [15:0] dato,
  input  logic        blank_ceros,
  output logic        ocupado,
  output logic [3:0]  an,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g
);

  localparam int             CW        = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [CW-1:0]  CNT_MAX   = CW'(PRESCALER - 1);
  localparam logic [CW-1:0]  CNT_GUARD = CW'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITOS - 1);

  // Scan state
  estado_t           state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Load / display state
  logic [15:0]       shadow_q, shadow_d;
  logic [15:0]       disp_q, disp_d;
  logic              ocupado_q, ocupado_d;
  // blank_ceros is registered so no input reaches the segment outputs
  // combinationally.
  logic              blank_q;

  logic              tick;
  logic              frame_end;
  logic              load;
  logic              commit;

  // tick only counts while actually scanning; the first enabled edge out of
  // OFF just restarts the slot at cnt=0 in GUARD.
  assign tick      = en && (state_q != ST_OFF) && (cnt_q == CNT_MAX);
  assign frame_end = tick && (idx_q == IDX_LAST);

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == ST_OFF) begin
      cnt_d   = '0;
      idx_d   = '0;
      state_d = (GUARD > 0) ? ST_GUARD : ST_ON;
    end else begin
      if (tick) begin
        cnt_d = '0;
        idx_d = idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      // The state follows the counter value it will hold next cycle, so the
      // guard window is exactly cnt = 0..GUARD-1 of every slot.
      state_d = (cnt_d < CNT_GUARD) ? ST_GUARD : ST_ON;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow / display register
  // ---------------------------------------------------------------------------
  // Commit only at a frame boundary, or while scanning is off (nothing is lit,
  // so no frame can tear). A load colliding with a commit is dropped because
  // load requires ocupado_q=0 and commit requires ocupado_q=1.
  assign load   = cargar && !ocupado_q;
  assign commit = ocupado_q && (frame_end || !en);

  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    ocupado_d = ocupado_q;
    if (load) begin
      shadow_d  = dato;
      ocupado_d = 1'b1;
    end else if (commit) begin
      disp_d    = shadow_q;
      ocupado_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= 16'h0000;
      disp_q    <= 16'h0000;
      ocupado_q <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      ocupado_q <= ocupado_d;
      blank_q   <= blank_ceros;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered state only)
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITOS-1:0][3:0] digitos;
  logic [NUM_DIGITOS-1:0]      ceros_arriba;  // nibble i and all above are 0
  logic [3:0]                  nib;
  logic [6:0]                  glifo;
  logic                        apagar;
  logic [6:0]                  seg;

  assign digitos = disp_q;
  assign nib     = digitos[idx_q];

  always_comb begin
    ceros_arriba = '0;
    ceros_arriba[NUM_DIGITOS-1] = (digitos[NUM_DIGITOS-1] == 4'h0);
    for (int i = NUM_DIGITOS - 2; i >= 1; i--) begin
      ceros_arriba[i] = ceros_arriba[i+1] && (digitos[i] == 4'h0);
    end
    // Digit 0 is always shown so a zero value still reads "0".
    ceros_arriba[0] = 1'b0;
  end

  assign apagar = blank_q && ceros_arriba[idx_q];

  decodificador_7seg u_dec (
    .valor_i (nib),
    .seg_o   (glifo)
  );

  // A blanked digit keeps its anode enabled but drives no segments, so the
  // per-slot timing is identical whether or not suppression is active.
  assign an  = (state_q == ST_ON) ? ~(4'b0001 << idx_q) : 4'b1111;
  assign seg = ((state_q == ST_ON) && !apagar) ? glifo : 7'b0000000;
  assign {a, b, c, d, e, f, g} = seg;
  assign ocupado = ocupado_q;

endmodule

// File: tb/tb_controlador_display.sv
module tb_controlador_display;

  localparam int P = 4;
  localparam int G = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cargar;
  logic [15:0] dato;
  logic        blank_ceros;
  logic        ocupado;
  logic [3:0]  an;
  logic        a, b, c, d, e, f, g;
  logic [6:0]  seg;

  assign seg = {a, b, c, d, e, f, g};

  always #5 clk = ~clk;

  controlador_display #(.PRESCALER(P), .GUARD(G)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cargar      (cargar),
    .dato        (dato),
    .blank_ceros (blank_ceros),
    .ocupado     (ocupado),
    .an          (an),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .e           (e),
    .f           (f),
    .g           (g)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]      dato;
    logic             blank;
    logic [3:0][6:0]  exp;   // exp[i] = expected segments {a..g} of digit i
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } slot_t;

  slot_t sb[$];
  vec_t  vecs[8];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push_digits(input logic [3:0][6:0] ex);
    slot_t s;
    for (int i = 0; i < 4; i++) begin
      s.an  = ~(4'b0001 << i);
      s.seg = ex[i];
      sb.push_back(s);
    end
  endtask

  // Called at the negedge of the first (guard) cycle of idx0; checks one full
  // frame and returns at the first negedge of the following frame.
  task automatic check_frame(input string tag);
    slot_t s;
    for (int sl = 0; sl < 4; sl++) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb_empty actual=0 required=1", tag);
        s.an  = 4'b0000;
        s.seg = 7'h7F;
      end else begin
        s = sb.pop_front();
      end
      for (int cy = 0; cy < P; cy++) begin
        if (cy < G) begin
          chk($sformatf("%s_s%0d_c%0d_guard_an", tag, sl, cy), {12'h0, an}, 16'h000F);
          chk($sformatf("%s_s%0d_c%0d_guard_seg", tag, sl, cy), {9'h0, seg}, 16'h0000);
        end else begin
          chk($sformatf("%s_s%0d_c%0d_an", tag, sl, cy), {12'h0, an}, {12'h0, s.an});
          chk($sformatf("%s_s%0d_c%0d_seg", tag, sl, cy), {9'h0, seg}, {9'h0, s.seg});
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_commit(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!ocupado) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_commit_seen"}, {15'h0, seen}, 16'h0001);
  endtask

  // Load a vector at a frame start, attempt a second (must-be-dropped) load,
  // then wait for the commit and check the next whole frame.
  task automatic run_vec(input int k);
    dato        = vecs[k].dato;
    blank_ceros = vecs[k].blank;
    cargar      = 1'b1;
    push_digits(vecs[k].exp);
    @(negedge clk);
    chk($sformatf("v%0d_ocupado_set", k), {15'h0, ocupado}, 16'h0001);
    dato = 16'hAAAA;
    @(negedge clk);
    cargar = 1'b0;
    chk($sformatf("v%0d_ocupado_hold", k), {15'h0, ocupado}, 16'h0001);
    wait_commit($sformatf("v%0d", k));
    check_frame($sformatf("v%0d", k));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h1234, 1'b0, {7'h30, 7'h6D, 7'h79, 7'h33}};
    vecs[1] = '{16'h0305, 1'b1, {7'h00, 7'h79, 7'h7E, 7'h5B}};
    vecs[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}};
    vecs[3] = '{16'hF8F8, 1'b0, {7'h47, 7'h7F, 7'h47, 7'h7F}};
    vecs[4] = '{16'h0000, 1'b0, {7'h7E, 7'h7E, 7'h7E, 7'h7E}};
    vecs[5] = '{16'h00A0, 1'b1, {7'h00, 7'h00, 7'h77, 7'h7E}};
    vecs[6] = '{16'hBCDE, 1'b1, {7'h1F, 7'h4E, 7'h3D, 7'h4F}};
    vecs[7] = '{16'h6709, 1'b0, {7'h5F, 7'h70, 7'h7E, 7'h7B}};

    rst_n       = 1'b0;
    en          = 1'b0;
    cargar      = 1'b0;
    dato        = 16'h0000;
    blank_ceros = 1'b0;

    #2;
    chk("reset_an", {12'h0, an}, 16'h000F);
    chk("reset_seg", {9'h0, seg}, 16'h0000);
    chk("reset_ocupado", {15'h0, ocupado}, 16'h0000);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_an", {12'h0, an}, 16'h000F);
    en = 1'b1;

    for (int k = 0; k < 8; k++) begin
      run_vec(k);
    end

    // en dropped mid-slot on idx2, with a load made while scanning is off:
    // the shadow must commit while off and show from the restarted frame.
    for (int n = 0; n < 2 * P + G; n++) @(negedge clk);
    chk("idx2_on_an", {12'h0, an}, 16'h000B);
    en          = 1'b0;
    cargar      = 1'b1;
    dato        = 16'h00E0;
    blank_ceros = 1'b1;
    push_digits({7'h00, 7'h00, 7'h4F, 7'h7E});
    @(negedge clk);
    cargar = 1'b0;
    chk("endrop_an", {12'h0, an}, 16'h000F);
    chk("endrop_seg", {9'h0, seg}, 16'h0000);
    chk("endrop_ocupado_set", {15'h0, ocupado}, 16'h0001);
    @(negedge clk);
    chk("endrop_ocupado_commit", {15'h0, ocupado}, 16'h0000);
    chk("endrop_an_hold", {12'h0, an}, 16'h000F);
    en = 1'b1;
    @(negedge clk);
    check_frame("enrise");

    // Asynchronous reset pulse between edges during ON with a load pending.
    blank_ceros = 1'b0;
    @(negedge clk);
    cargar = 1'b1;
    dato   = 16'h5555;
    @(negedge clk);
    cargar = 1'b0;
    chk("prerst_ocupado", {15'h0, ocupado}, 16'h0001);
    chk("prerst_an", {12'h0, an}, 16'h000E);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", {12'h0, an}, 16'h000F);
    chk("arst_seg", {9'h0, seg}, 16'h0000);
    chk("arst_ocupado", {15'h0, ocupado}, 16'h0000);
    #1;
    rst_n = 1'b1;
    push_digits({7'h7E, 7'h7E, 7'h7E, 7'h7E});
    @(negedge clk);
    check_frame("postrst");

    chk("sb_drained", 16'(sb.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controlador_display.md
CONTROLADOR_DISPLAY -- requirements
Module: controlador_display

Interface
REQ-001 SHALL have parameter PRESCALER, default 50000, clock cycles per digit slot (>= GUARD+1).
REQ-002 SHALL have parameter GUARD, default 2, all-digits-off cycles at start of each slot (ghosting guard).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  scan enable.
REQ-006 SHALL have port cargar  input  1  load strobe for dato.
REQ-007 SHALL have port dato  input  16  four hex digits; dato[3:0] = digit 0 (rightmost).
REQ-008 SHALL have port blank_ceros  input  1  leading-zero suppression enable.
REQ-009 SHALL have port ocupado  output  1  shadow holds a load not yet shown.
REQ-010 SHALL have port an  output  4  digit enables, active-low; an[i] = digit i.
REQ-011 SHALL have ports a, b, c, d, e, f, g  output  1 each  segments, active-high, standard lettering (a top, clockwise, g middle).

Function
REQ-012 Slot counter cnt SHALL count 0..PRESCALER-1 while en=1; tick when cnt=PRESCALER-1, then cnt wraps to 0.
REQ-013 Digit index idx SHALL advance on tick, 0->1->2->3->0; frame_end = tick with idx=3.
REQ-014 States per slot: GUARD (cnt<GUARD, an=4'b1111, segments 0) then ON (an[idx]=0, others 1).
REQ-015 In ON, segments SHALL show hex decode of display-register nibble idx; 0-9 and A,b,C,d,E,F glyphs.
REQ-016 Outputs SHALL be functions of registered state only; no combinational path from any input to an/segments.
REQ-017 cargar=1 with ocupado=0 SHALL copy dato into shadow and set ocupado on that edge.
REQ-018 cargar=1 with ocupado=1 SHALL be ignored (load dropped, shadow unchanged).
REQ-019 On frame_end with ocupado=1, shadow SHALL copy into display register and ocupado clear, same edge; displayed value never changes mid-frame.
REQ-020 Simultaneous cargar and frame_end with ocupado=1: old shadow committed, new load dropped; with ocupado=0: new value latched, committed at next frame_end.
REQ-021 en=0 SHALL force an=4'b1111, segments 0, cnt=0, idx=0 on next edge; pending shadow SHALL commit on that edge (no tearing risk).
REQ-022 Re-assertion of en SHALL restart at idx=0, cnt=0, GUARD state.
REQ-023 blank_ceros=1: digit i (i=3..1) SHALL blank (segments 0, an per REQ-014) when nibble i and all higher nibbles are 0; digit 0 never blanked.

Reset
REQ-024 rst_n=0 SHALL immediately, without clock, force an=4'b1111, a..g=0, ocupado=0, cnt=0, idx=0, display and shadow registers = 16'h0000.
REQ-025 Reset mid-slot or mid-load SHALL discard all pending data; after release, scanning starts at idx=0 GUARD when en=1.

Structure
REQ-026 Shared package display_pkg SHALL hold the 16 seven-bit glyph constants (order a..g) and digit-count constant 4.
REQ-027 Hex-to-segment decode SHALL be sub-module decodificador_7seg (4-bit in, 7-bit out, purely combinational).
REQ-028 Scan counter/FSM and load/shadow logic SHALL remain in controlador_display.

Verification (PRESCALER=4, GUARD=1: slot 4 cycles, frame 16)
REQ-029 Reset, en=1, cargar 1 cycle with dato=16'h1234 -> ocupado=1 until first frame_end; next frame idx0 slot: cycle 1 an=1111, cycles 2-4 an=1110, b,c,f,g=1, a,d,e=0 ("4").
REQ-030 cargar dato=16'hAAAA while ocupado=1 -> ignored; display later shows 16'h1234, never AAAA.
REQ-031 blank_ceros=1, dato=16'h0305 -> digit 3 blank, digit 2 "3", digit 1 "0" (a..f=1, g=0), digit 0 "5"; dato=16'h0000 -> only digit 0 lit "0".
REQ-032 Digit value F -> a,e,f,g=1, b,c,d=0; value 8 -> all seven segments 1.
REQ-033 en dropped mid-slot idx=2 -> an=1111 next edge; en raised -> idx0 GUARD cycle, then an=1110.
REQ-034 rst_n pulsed low between clock edges during ON -> an=1111, a..g=0, ocupado=0 before next edge; display reg reads 0 after release.
